// File: rtl/rv_lsu_misalign_seq.sv
// Q103H load/store sequencer: passes aligned accesses through, splits word-crossing
// accesses into byte accesses under stall, and reassembles split loads in Q104H.
module rv_lsu_misalign_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_Q103H,
  input  logic [31:0] addr_Q103H,
  input  logic [31:0] wr_data_Q103H,
  input  logic        wr_en_Q103H,
  input  logic        is_signed_Q103H,
  input  logic [3:0]  byte_en_Q103H,
  output logic        stall_Q103H,
  output logic [31:0] mem_addr_Q103H,
  output logic [31:0] mem_wr_data_Q103H,
  output logic        mem_wr_en_Q103H,
  output logic        mem_is_signed_Q103H,
  output logic [3:0]  mem_byte_en_Q103H,
  input  logic [31:0] mem_rd_data_Q104H,
  output logic [31:0] rd_data_Q104H,
  output logic        rd_valid_Q104H
);

  typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;

  state_t      r_state, w_state_next;
  logic [1:0]  r_idx, w_idx_next;
  logic [1:0]  r_last;
  logic [31:0] r_addr, r_wdata;
  logic        r_wen, r_signed;

  logic        w_split_req, w_in_split, w_split_issue, w_final;
  logic [1:0]  w_last_in, w_k;
  logic [31:0] w_base_addr, w_base_data;
  logic        w_base_wen, w_base_signed, w_issue_load;
  logic [7:0]  w_wr_byte;

  // Q104H pipeline registers and load assembly lanes 0..2
  logic        r_load_q, r_split_q, r_final_q, r_signed_q;
  logic [1:0]  r_idx_q;
  logic [2:0]  r_n_q;
  logic [23:0] r_asm;

  assign w_split_req = (r_state == S_IDLE) && req_valid_Q103H &&
                       (((byte_en_Q103H == 4'b0011) && (addr_Q103H[1:0] == 2'd3)) ||
                        ((byte_en_Q103H == 4'b1111) && (addr_Q103H[1:0] != 2'd0)));
  assign w_last_in     = (byte_en_Q103H == 4'b1111) ? 2'd3 : 2'd1;
  assign w_in_split    = (r_state == S_SPLIT);
  assign w_split_issue = w_in_split || w_split_req;
  assign w_final       = w_in_split && (r_idx == r_last);
  assign w_k           = w_in_split ? r_idx : 2'd0;
  assign w_base_addr   = w_in_split ? r_addr   : addr_Q103H;
  assign w_base_data   = w_in_split ? r_wdata  : wr_data_Q103H;
  assign w_base_wen    = w_in_split ? r_wen    : wr_en_Q103H;
  assign w_base_signed = w_in_split ? r_signed : is_signed_Q103H;
  assign w_wr_byte     = w_base_data[{w_k, 3'b000} +: 8];
  assign w_issue_load  = w_split_issue ? !w_base_wen : (req_valid_Q103H && !wr_en_Q103H);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_split_req) begin
      r_addr   <= addr_Q103H;
      r_wdata  <= wr_data_Q103H;
      r_wen    <= wr_en_Q103H;
      r_signed <= is_signed_Q103H;
      r_last   <= w_last_in;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        if (w_split_req) begin
          w_state_next = S_SPLIT;
          w_idx_next   = 2'd1;
        end
      end
      S_SPLIT: begin
        if (r_idx == r_last) begin
          w_state_next = S_IDLE;
          w_idx_next   = 2'd0;
        end else begin
          w_idx_next = r_idx + 2'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = 2'd0;
      end
    endcase
  end

  always_comb begin
    mem_addr_Q103H      = addr_Q103H;
    mem_wr_data_Q103H   = wr_data_Q103H;
    mem_wr_en_Q103H     = req_valid_Q103H && wr_en_Q103H;
    mem_is_signed_Q103H = is_signed_Q103H;
    mem_byte_en_Q103H   = byte_en_Q103H;
    stall_Q103H         = 1'b0;
    if (w_split_issue) begin
      mem_addr_Q103H      = w_base_addr + {30'd0, w_k};
      mem_wr_data_Q103H   = {24'd0, w_wr_byte};
      mem_wr_en_Q103H     = w_base_wen;
      mem_is_signed_Q103H = 1'b0;
      mem_byte_en_Q103H   = 4'b0001;
      stall_Q103H         = !w_final;
    end
    // Reset wins over an in-flight sequence: nothing further may be written.
    if (!rst_n) begin
      stall_Q103H     = 1'b0;
      mem_wr_en_Q103H = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_load_q   <= 1'b0;
      r_split_q  <= 1'b0;
      r_idx_q    <= 2'd0;
      r_final_q  <= 1'b0;
      r_n_q      <= 3'd0;
      r_signed_q <= 1'b0;
    end else begin
      r_load_q   <= w_issue_load;
      r_split_q  <= w_split_issue;
      r_idx_q    <= w_k;
      r_final_q  <= w_final;
      r_n_q      <= {1'b0, (w_in_split ? r_last : w_last_in)} + 3'd1;
      r_signed_q <= w_base_signed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_asm <= 24'd0;
    end else if (r_load_q && r_split_q && !r_final_q) begin
      case (r_idx_q)
        2'd0:    r_asm[7:0]   <= mem_rd_data_Q104H[7:0];
        2'd1:    r_asm[15:8]  <= mem_rd_data_Q104H[7:0];
        default: r_asm[23:16] <= mem_rd_data_Q104H[7:0];
      endcase
    end
  end

  always_comb begin
    rd_data_Q104H  = 32'd0;
    rd_valid_Q104H = 1'b0;
    if (r_load_q) begin
      if (!r_split_q) begin
        rd_data_Q104H  = mem_rd_data_Q104H;
        rd_valid_Q104H = 1'b1;
      end else if (r_final_q) begin
        rd_valid_Q104H = 1'b1;
        if (r_n_q == 3'd4)
          rd_data_Q104H = {mem_rd_data_Q104H[7:0], r_asm};
        else
          rd_data_Q104H = {{16{r_signed_q && mem_rd_data_Q104H[7]}},
                           mem_rd_data_Q104H[7:0], r_asm[7:0]};
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu_misalign_seq.sv
// Bench for rv_lsu_misalign_seq: byte-addressed memory behind the DUT, plus a
// reference memory updated per instruction to predict load results and contents.
module tb_rv_lsu_misalign_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_Q103H = 1'b0;
  logic [31:0] addr_Q103H = 32'd0;
  logic [31:0] wr_data_Q103H = 32'd0;
  logic        wr_en_Q103H = 1'b0;
  logic        is_signed_Q103H = 1'b0;
  logic [3:0]  byte_en_Q103H = 4'b0000;
  logic        stall_Q103H;
  logic [31:0] mem_addr_Q103H, mem_wr_data_Q103H;
  logic        mem_wr_en_Q103H, mem_is_signed_Q103H;
  logic [3:0]  mem_byte_en_Q103H;
  logic [31:0] mem_rd_data_Q104H = 32'd0;
  logic [31:0] rd_data_Q104H;
  logic        rd_valid_Q104H;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  dmem    [logic [31:0]];
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] issued_q [$];

  always #5 clk = ~clk;

  rv_lsu_misalign_seq dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_valid_Q103H     (req_valid_Q103H),
    .addr_Q103H          (addr_Q103H),
    .wr_data_Q103H       (wr_data_Q103H),
    .wr_en_Q103H         (wr_en_Q103H),
    .is_signed_Q103H     (is_signed_Q103H),
    .byte_en_Q103H       (byte_en_Q103H),
    .stall_Q103H         (stall_Q103H),
    .mem_addr_Q103H      (mem_addr_Q103H),
    .mem_wr_data_Q103H   (mem_wr_data_Q103H),
    .mem_wr_en_Q103H     (mem_wr_en_Q103H),
    .mem_is_signed_Q103H (mem_is_signed_Q103H),
    .mem_byte_en_Q103H   (mem_byte_en_Q103H),
    .mem_rd_data_Q104H   (mem_rd_data_Q104H),
    .rd_data_Q104H       (rd_data_Q104H),
    .rd_valid_Q104H      (rd_valid_Q104H)
  );

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] dm_rd(input logic [31:0] a);
    return dmem.exists(a) ? dmem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int size_of(input logic [3:0] be);
    return (be == 4'b1111) ? 4 : (be == 4'b0011) ? 2 : 1;
  endfunction

  // Number of byte accesses the sequencer should issue for this instruction
  function automatic int pieces(input logic [31:0] a, input logic [3:0] be);
    if (be == 4'b0011 && a[1:0] == 2'd3) return 2;
    if (be == 4'b1111 && a[1:0] != 2'd0) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [3:0] be, input bit sg);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < size_of(be); i++) v[8*i +: 8] = ref_rd(a + 32'(i));
    if (size_of(be) == 1 && sg && v[7])  v[31:8]  = 24'hFFFFFF;
    if (size_of(be) == 2 && sg && v[15]) v[31:16] = 16'hFFFF;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < size_of(be); i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
  endtask

  // Data memory: registered read of the access size, byte-lane writes
  always @(posedge clk) begin
    logic [31:0] w;
    logic [31:0] rv;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = dm_rd(mem_addr_Q103H + 32'(i));
    case (mem_byte_en_Q103H)
      4'b0001: rv = {{24{mem_is_signed_Q103H & w[7]}}, w[7:0]};
      4'b0011: rv = {{16{mem_is_signed_Q103H & w[15]}}, w[15:0]};
      default: rv = w;
    endcase
    mem_rd_data_Q104H <= rv;
    if (mem_wr_en_Q103H)
      for (int i = 0; i < 4; i++)
        if (mem_byte_en_Q103H[i]) dmem[mem_addr_Q103H + 32'(i)] = mem_wr_data_Q103H[8*i +: 8];
  end

  // Presents one instruction and holds it until stall drops; returns stall count,
  // the Q104H output seen in the first issue cycle, and bad non-final split outputs.
  task automatic do_access(input bit wr, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input bit sg, output int stalls,
                           output logic pv, output logic [31:0] pd, output int bad);
    int guard;
    req_valid_Q103H = 1'b1; wr_en_Q103H = wr; addr_Q103H = a;
    wr_data_Q103H = d; byte_en_Q103H = be; is_signed_Q103H = sg;
    issued_q.delete();
    stalls = 0; bad = 0; guard = 0;
    @(negedge clk);
    pv = rd_valid_Q104H; pd = rd_data_Q104H;
    issued_q.push_back(mem_addr_Q103H);
    while (stall_Q103H && guard < 16) begin
      stalls++; guard++;
      @(posedge clk); #1;
      addr_Q103H = $urandom; wr_data_Q103H = $urandom; is_signed_Q103H = $urandom_range(0, 1);
      @(negedge clk);
      if (rd_valid_Q104H !== 1'b0 || (!wr && rd_data_Q104H !== 32'd0)) bad++;
      issued_q.push_back(mem_addr_Q103H);
    end
    if (guard >= 16) stalls = -1;
    @(posedge clk); #1;
    req_valid_Q103H = 1'b0;
  endtask

  task automatic sample_q104(output logic v, output logic [31:0] d);
    @(negedge clk);
    v = rd_valid_Q104H; d = rd_data_Q104H;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req_valid_Q103H = 1'b1; wr_en_Q103H = 1'b1; addr_Q103H = 32'h401;
    wr_data_Q103H = 32'hCAFEF00D; byte_en_Q103H = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (stall_Q103H !== 1'b0 || mem_wr_en_Q103H !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs stall=%b wr_en=%b expected 0 0", stall_Q103H, mem_wr_en_Q103H);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid_Q103H = 1'b0;
    @(negedge clk);
    n_tests++;
    if (rd_valid_Q104H !== 1'b0 || rd_data_Q104H !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_rd valid=%b data=%h expected 0 00000000", rd_valid_Q104H, rd_data_Q104H);
    end
    @(posedge clk); #1;
    $display("[TB] reset done");
  endtask

  task automatic test_aligned;
    int st, bad; logic pv, v; logic [31:0] pd, d;
    ref_store(32'h100, 32'hDEADBEEF, 4'b1111);
    for (int i = 0; i < 4; i++) dmem[32'h100 + 32'(i)] = ref_mem[32'h100 + 32'(i)];
    do_access(1'b0, 32'h100, 32'd0, 4'b1111, 1'b0, st, pv, pd, bad);
    sample_q104(v, d);
    n_tests++;
    if (st !== 0 || v !== 1'b1 || d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL aligned_lw stalls=%0d valid=%b data=%h expected 0 1 deadbeef", st, v, d);
    end
    $display("[TB] LW 0x100 stalls=%0d data=%h", st, d);
  endtask

  task automatic test_store_split;
    int st, bad; logic pv, v; logic [31:0] pd, d, got;
    do_access(1'b1, 32'h101, 32'h11223344, 4'b1111, 1'b0, st, pv, pd, bad);
    ref_store(32'h101, 32'h11223344, 4'b1111);
    n_tests++;
    if (st !== 3 || issued_q.size() != 4) begin
      n_fail++;
      $display("FAIL sw_split_stalls stalls=%0d issues=%0d expected 3 4", st, issued_q.size());
    end
    for (int i = 0; i < 4; i++) got[8*i +: 8] = dm_rd(32'h101 + 32'(i));
    n_tests++;
    if (got !== 32'h11223344) begin
      n_fail++;
      $display("FAIL sw_split_bytes got=%h expected 11223344", got);
    end
    do_access(1'b0, 32'h101, 32'd0, 4'b1111, 1'b1, st, pv, pd, bad);
    sample_q104(v, d);
    n_tests++;
    if (st !== 3 || bad !== 0 || v !== 1'b1 || d !== 32'h11223344) begin
      n_fail++;
      $display("FAIL lw_split stalls=%0d bad=%0d valid=%b data=%h expected 3 0 1 11223344", st, bad, v, d);
    end
    sample_q104(v, d);
    n_tests++;
    if (v !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_split_once valid=%b expected 0", v);
    end
    $display("[TB] SW/LW 0x101 stalls=%0d data=%h", st, d);
  endtask

  task automatic test_half;
    int st, bad; logic pv, v; logic [31:0] pd, d;
    logic [7:0] b102, b105;
    ref_mem[32'h103] = 8'h80; ref_mem[32'h104] = 8'hFF;
    dmem[32'h103] = 8'h80; dmem[32'h104] = 8'hFF;
    do_access(1'b0, 32'h103, 32'd0, 4'b0011, 1'b1, st, pv, pd, bad);
    sample_q104(v, d);
    n_tests++;
    if (st !== 1 || v !== 1'b1 || d !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL lh_split stalls=%0d valid=%b data=%h expected 1 1 ffffff80", st, v, d);
    end
    do_access(1'b0, 32'h103, 32'd0, 4'b0011, 1'b0, st, pv, pd, bad);
    sample_q104(v, d);
    n_tests++;
    if (st !== 1 || v !== 1'b1 || d !== 32'h0000FF80) begin
      n_fail++;
      $display("FAIL lhu_split stalls=%0d valid=%b data=%h expected 1 1 0000ff80", st, v, d);
    end
    b102 = ref_rd(32'h102); b105 = ref_rd(32'h105);
    do_access(1'b1, 32'h103, 32'h0000ABCD, 4'b0011, 1'b0, st, pv, pd, bad);
    n_tests++;
    if (dm_rd(32'h103) !== 8'hCD || dm_rd(32'h104) !== 8'hAB ||
        dm_rd(32'h102) !== b102 || dm_rd(32'h105) !== b105) begin
      n_fail++;
      $display("FAIL sh_split bytes102..105=%h %h %h %h expected %h cd ab %h",
               dm_rd(32'h102), dm_rd(32'h103), dm_rd(32'h104), dm_rd(32'h105), b102, b105);
    end
    ref_store(32'h103, 32'h0000ABCD, 4'b0011);
    $display("[TB] LH/LHU/SH 0x103 done");
  endtask

  task automatic test_wrap;
    int st, bad; logic pv, v; logic [31:0] pd, d, exp_d;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFFFFFF; exp_a[1] = 32'h0; exp_a[2] = 32'h1; exp_a[3] = 32'h2;
    exp_d = ref_load(32'hFFFFFFFF, 4'b1111, 1'b0);
    do_access(1'b0, 32'hFFFFFFFF, 32'd0, 4'b1111, 1'b0, st, pv, pd, bad);
    sample_q104(v, d);
    n_tests++;
    if (issued_q.size() != 4) begin
      n_fail++;
      $display("FAIL wrap_issue_count got=%0d expected 4", issued_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (issued_q[i] !== exp_a[i]) begin
          n_fail++;
          $display("FAIL wrap_addr%0d got=%h expected %h", i, issued_q[i], exp_a[i]);
        end
      end
    end
    n_tests++;
    if (v !== 1'b1 || d !== exp_d) begin
      n_fail++;
      $display("FAIL wrap_data valid=%b data=%h expected 1 %h", v, d, exp_d);
    end
    $display("[TB] LW 0xFFFFFFFF data=%h", d);
  endtask

  task automatic test_reset_mid_split;
    int st, bad; logic pv, v; logic [31:0] pd, d, exp_d;
    logic [7:0] old_b [4];
    for (int i = 0; i < 4; i++) old_b[i] = ref_rd(32'h201 + 32'(i));
    req_valid_Q103H = 1'b1; wr_en_Q103H = 1'b1; addr_Q103H = 32'h201;
    wr_data_Q103H = 32'h55667788; byte_en_Q103H = 4'b1111; is_signed_Q103H = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_Q103H !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_issue0_stall got=%b expected 1", stall_Q103H);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_Q103H !== 1'b0 || mem_wr_en_Q103H !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_in_reset stall=%b wr_en=%b expected 0 0", stall_Q103H, mem_wr_en_Q103H);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid_Q103H = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_Q103H !== 1'b0 || mem_wr_en_Q103H !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_idle stall=%b wr_en=%b expected 0 0", stall_Q103H, mem_wr_en_Q103H);
    end
    @(posedge clk); #1;
    n_tests++;
    if (dm_rd(32'h201) !== 8'h88 || dm_rd(32'h202) !== old_b[1] ||
        dm_rd(32'h203) !== old_b[2] || dm_rd(32'h204) !== old_b[3]) begin
      n_fail++;
      $display("FAIL midrst_bytes got=%h %h %h %h expected 88 %h %h %h", dm_rd(32'h201),
               dm_rd(32'h202), dm_rd(32'h203), dm_rd(32'h204), old_b[1], old_b[2], old_b[3]);
    end
    ref_mem[32'h201] = 8'h88;
    exp_d = ref_load(32'h200, 4'b1111, 1'b0);
    do_access(1'b0, 32'h200, 32'd0, 4'b1111, 1'b0, st, pv, pd, bad);
    sample_q104(v, d);
    n_tests++;
    if (st !== 0 || v !== 1'b1 || d !== exp_d) begin
      n_fail++;
      $display("FAIL midrst_lw stalls=%0d valid=%b data=%h expected 0 1 %h", st, v, d, exp_d);
    end
    $display("[TB] reset mid-split, LW 0x200 data=%h", d);
  endtask

  task automatic test_back_to_back;
    int st, bad, n, errs;
    logic pv, v; logic [31:0] pd, d, a, wd, exp_d, prev_d;
    logic [3:0] be; bit wr, sg, prev_load;
    prev_load = 1'b0; prev_d = 32'd0;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                      : 32'h300 + 32'($urandom_range(0, 15));
      case ($urandom_range(0, 2))
        0:       be = 4'b0001;
        1:       be = 4'b0011;
        default: be = 4'b1111;
      endcase
      wr = $urandom_range(0, 1); sg = $urandom_range(0, 1); wd = $urandom;
      n = pieces(a, be);
      exp_d = ref_load(a, be, sg);
      do_access(wr, a, wd, be, sg, st, pv, pd, bad);
      if (wr) ref_store(a, wd, be);
      if (i > 0) begin
        n_tests++;
        if (pv !== prev_load || (prev_load && pd !== prev_d)) begin
          n_fail++;
          $display("FAIL b2b_result%0d valid=%b data=%h expected %b %h", i - 1, pv, pd, prev_load, prev_d);
        end
      end
      errs = 0;
      if (issued_q.size() != n) errs++;
      else for (int k = 0; k < n; k++) if (issued_q[k] !== a + 32'(k)) errs++;
      n_tests++;
      if (st !== n - 1 || bad !== 0 || errs !== 0) begin
        n_fail++;
        $display("FAIL b2b_issue%0d addr=%h be=%b stalls=%0d bad=%0d addr_errs=%0d expected %0d 0 0",
                 i, a, be, st, bad, errs, n - 1);
      end
      $display("[TB] b2b %0d %s addr=%h be=%b stalls=%0d", i, wr ? "ST" : "LD", a, be, st);
      prev_load = !wr; prev_d = exp_d;
    end
    sample_q104(v, d);
    n_tests++;
    if (v !== prev_load || (prev_load && d !== prev_d)) begin
      n_fail++;
      $display("FAIL b2b_last valid=%b data=%h expected %b %h", v, d, prev_load, prev_d);
    end
    errs = 0;
    foreach (ref_mem[k]) if (dm_rd(k) !== ref_mem[k]) errs++;
    foreach (dmem[k]) if (dmem[k] !== ref_rd(k)) errs++;
    n_tests++;
    if (errs != 0) begin
      n_fail++;
      $display("FAIL b2b_memory mismatching_bytes=%0d expected 0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_store_split();
    test_half();
    test_wrap();
    test_reset_mid_split();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
